// File: rtl/inst_queue.sv
// Instruction queue between fetcher and Decoder: circular FIFO of {inst, pc}
// with show-ahead head, back-pressure with slack, and mispredict flush.
module inst_queue #(
  parameter int IQ_DEPTH     = 16,
  parameter int IQ_PTR_WIDTH = 4,
  parameter int FULL_SLACK   = 1,
  parameter int INST_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  IF_inst_valid,
  input  logic [INST_WIDTH-1:0] IF_inst,
  input  logic [ADDR_WIDTH-1:0] IF_pc,
  output logic                  IQ_is_full,
  output logic                  IQ_inst_valid,
  output logic [INST_WIDTH-1:0] IQ_inst,
  output logic [ADDR_WIDTH-1:0] IQ_pc,
  input  logic                  ID_ready,
  input  logic                  ROB_clear
);

  localparam logic [IQ_PTR_WIDTH:0]   DEPTH_CNT = (IQ_PTR_WIDTH+1)'(IQ_DEPTH);
  localparam logic [IQ_PTR_WIDTH:0]   FULL_CNT  = (IQ_PTR_WIDTH+1)'(IQ_DEPTH - FULL_SLACK);
  localparam logic [IQ_PTR_WIDTH:0]   CNT_ONE   = (IQ_PTR_WIDTH+1)'(1);
  localparam logic [IQ_PTR_WIDTH-1:0] PTR_ONE   = IQ_PTR_WIDTH'(1);

  logic [IQ_PTR_WIDTH-1:0] head_reg, head_next;
  logic [IQ_PTR_WIDTH-1:0] tail_reg, tail_next;
  logic [IQ_PTR_WIDTH:0]   count_reg, count_next;

  logic [INST_WIDTH-1:0] inst_mem [IQ_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [IQ_DEPTH];

  logic push;
  logic pop;

  // Flush masks the head immediately so the Decoder never takes a squashed entry.
  assign IQ_inst_valid = (count_reg != '0) && !ROB_clear;
  assign IQ_inst       = inst_mem[head_reg];
  assign IQ_pc         = pc_mem[head_reg];
  assign IQ_is_full    = (count_reg >= FULL_CNT);

  assign push = IF_inst_valid && (count_reg != DEPTH_CNT);
  assign pop  = IQ_inst_valid && ID_ready;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (rdy) begin
      if (ROB_clear) begin
        head_next  = '0;
        tail_next  = '0;
        count_next = '0;
      end else begin
        if (push) tail_next = tail_reg + PTR_ONE;
        if (pop)  head_next = head_reg + PTR_ONE;
        case ({push, pop})
          2'b10:   count_next = count_reg + CNT_ONE;
          2'b01:   count_next = count_reg - CNT_ONE;
          default: count_next = count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (rdy && !ROB_clear && push) begin
      inst_mem[tail_reg] <= IF_inst;
      pc_mem[tail_reg]   <= IF_pc;
    end
  end

endmodule
